dp_scoreboard: RTL
==================

Name: dp_scoreboard

Overview:
- Parametrised vector dispatch scoreboard between the decoder and the per-FU issue queues.
- Buffers up to DEPTH decoded instructions and tracks RAW/WAW/WAR hazards on the vector register file with dependency matrices.
- Each cycle it dispatches the oldest hazard-free instruction whose FU is ready.
- Retires entries on completion responses tagged with the entry id. Generalises the fixed 8-entry, 6-FU dispatch stage with real retirement, flush and occupancy.

Parameters:
- DEPTH, 8, number of scoreboard entries (2..16).
- NFU, 6, number of functional-unit channels.
- NREG, 32, number of vector registers (width of source/dest masks).
- PW, 64, opaque payload width forwarded to the FU.
- ID_W, $clog2(DEPTH), entry id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  decoder request valid.
- in_ready  out  1  a free entry exists.
- in_fu  in  $clog2(NFU)  target FU index.
- in_has_vd  in  1  instruction writes a vector register.
- in_vd  in  $clog2(NREG)  destination register.
- in_vs_mask  in  NREG  source register set (one bit per register read, mask register included).
- in_payload  in  PW  opaque instruction payload.
- fu_ready  in  NFU  per-FU accept.
- dp_valid  out  NFU  one-hot dispatch valid (at most one bit set).
- dp_id  out  ID_W  entry id of the dispatched instruction.
- dp_payload  out  PW  payload of the dispatched instruction.
- vd_done_valid  in  NFU  per-FU writeback-complete pulse.
- vd_done_id  in  NFU*ID_W  entry id for each vd_done.
- vs_done_valid  in  NFU  per-FU source-read-complete pulse.
- vs_done_id  in  NFU*ID_W  entry id for each vs_done.
- occupancy  out  ID_W+1  number of valid entries.

Behaviour:
- Reset: all entries invalid, all matrices zero, dp_valid=0, dp_id=0, dp_payload=0, occupancy=0, in_ready=1.
- Entry state: valid, issued, vd_done, vs_done, fu, vd, has_vd, vs_mask, payload; row dep_vd[i] and row dep_vs[i] (DEPTH bits each); age row older[i] (bit j set means j is older than i).

Allocate:
- Fires on in_valid & in_ready. Uses the lowest-index free slot, where free is taken from registered state.
- A slot freed this cycle is reusable next cycle only. in_ready is combinational.
- older[new] = current valid vector.
- dep_vd[new][j] = valid[j] & has_vd[j] & !vd_done_eff[j] & (in_vs_mask[vd[j]] | (in_has_vd & in_vd==vd[j])). This covers RAW and WAW.
- dep_vs[new][j] = valid[j] & in_has_vd & vs_mask[j][in_vd] & !vs_done_eff[j]. This covers WAR.
- *_eff includes responses arriving in the same cycle, so no stale dependency is recorded.

Response:
- vd_done for id k sets vd_done[k] and clears column k of dep_vd.
- vs_done for id k sets vs_done[k] and clears column k of dep_vs.
- Multiple FUs responding in one cycle are all applied.

Ready and select:
- ready[i] = valid & !issued & dep_vd[i]==0 & dep_vs[i]==0 & fu_ready[fu[i]].
- Selected entry = ready[i] with no ready j such that older[i][j].
- dp_valid = onehot(fu of selected) if any ready, else 0.
- dp_id and dp_payload are combinational from the selected entry.
- Dispatch occurs that cycle, because ready already includes fu_ready. Set issued.
- At issue: if !has_vd, set vd_done; if vs_mask==0, set vs_done.
- An entry allocated this cycle cannot dispatch before the next cycle (latency min 1 cycle from in_valid to dp_valid).

Retire:
- Entry with valid & issued & vd_done & vs_done is cleared at the next edge. Clear its older column.
- A response for an invalid or unissued id is ignored (assertion in sim).

Flush:
- Clears valid, issued and all matrices for every entry. It has priority over same-cycle allocate and responses.
- No dispatch is presented in the flush cycle (dp_valid forced 0).

Other rules:
- occupancy is registered and updates with alloc/retire/flush; simultaneous alloc and retire gives a net 0 change.
- Full: in_ready=0, in_valid is held, and no state changes from it.
- Reset mid-operation: immediate return to reset values, outstanding responses are dropped.

Decomposition:
- dp_pkg: FU index constants (ALU, MAC, LD, ST, MSK, SLD), the dp_entry_t struct, and the default DEPTH/NREG constants.
- Sub-module dp_age_select(DEPTH): takes the older matrix and the ready vector, and outputs the oldest-ready one-hot plus an any flag. It is combinational and reusable by the issue queues.

Test Plan:
1. Independent: alloc ALU (vd=v1, vs={v2}) then MAC (vd=v3, vs={v4}), all fu_ready=1 -> ALU dispatched cycle+1 with id 0, MAC cycle+2 with id 1; occupancy 2, then 0 after both vd_done/vs_done.
2. RAW: ALU vd=v1, then LD-independent ST with vs={v1} -> ST is held until ALU vd_done(id 0) is pulsed; ST dp_valid is asserted in the cycle after the pulse. A vd_done pulsed in the same cycle as ST alloc gives no dependency, and ST dispatches next cycle.
3. WAR/WAW: MAC vs={v5} issued without vs_done, then ALU vd=v5 -> ALU blocked until vs_done(id 0); a second ALU vd=v5 also waits on the first ALU's vd_done.
4. Age priority: three ready entries ids 2, 0, 1 allocated in that order, all to blocked FU; raise fu_ready -> dispatch order is id 2, 0, 1.
5. Full/reuse: fill DEPTH=8 -> in_ready=0, occupancy=8. Retire id 3 -> in_ready=1 the next cycle, and the new alloc lands in slot 3.
6. Flush with 5 pending plus a same-cycle in_valid and vd_done -> occupancy 0, dp_valid=0, and the allocation is not taken. Async rst_n low mid-dispatch -> all outputs go to reset values immediately.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared constants and per-entry status for the vector dispatch scoreboard.
package dp_pkg;

  localparam int FU_ALU = 0;
  localparam int FU_MAC = 1;
  localparam int FU_LD  = 2;
  localparam int FU_ST  = 3;
  localparam int FU_MSK = 4;
  localparam int FU_SLD = 5;

  localparam int DP_NFU   = 6;
  localparam int DP_DEPTH = 8;
  localparam int DP_NREG  = 32;

  typedef struct packed {
    logic valid;
    logic issued;
    logic has_vd;
    logic vd_done;
    logic vs_done;
  } dp_entry_t;

endpackage

// File: rtl/dp_age_select.sv
// Picks the oldest entry among a ready set using an age matrix
// (older[i][j] set means j is older than i).
module dp_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  input  logic [DEPTH-1:0]            ready,
  output logic [DEPTH-1:0]            grant,
  output logic                        any
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i] & ~(|(older[i] & ready));
    end
  end

  assign any = |ready;

endmodule

// File: rtl/dp_scoreboard.sv
// Vector dispatch scoreboard: buffers decoded instructions, tracks RAW/WAW/WAR
// hazards with dependency matrices and issues the oldest hazard-free entry.
module dp_scoreboard
  import dp_pkg::*;
#(
  parameter int DEPTH = DP_DEPTH,
  parameter int NFU   = DP_NFU,
  parameter int NREG  = DP_NREG,
  parameter int PW    = 64,
  parameter int ID_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(NFU)-1:0]    in_fu,
  input  logic                      in_has_vd,
  input  logic [$clog2(NREG)-1:0]   in_vd,
  input  logic [NREG-1:0]           in_vs_mask,
  input  logic [PW-1:0]             in_payload,
  input  logic [NFU-1:0]            fu_ready,
  output logic [NFU-1:0]            dp_valid,
  output logic [ID_W-1:0]           dp_id,
  output logic [PW-1:0]             dp_payload,
  input  logic [NFU-1:0]            vd_done_valid,
  input  logic [NFU*ID_W-1:0]       vd_done_id,
  input  logic [NFU-1:0]            vs_done_valid,
  input  logic [NFU*ID_W-1:0]       vs_done_id,
  output logic [ID_W:0]             occupancy
);

  localparam int FU_W  = $clog2(NFU);
  localparam int REG_W = $clog2(NREG);

  dp_entry_t [DEPTH-1:0]       ent;
  logic [FU_W-1:0]             fu_q  [DEPTH];
  logic [REG_W-1:0]            vd_q  [DEPTH];
  logic [NREG-1:0]             vs_q  [DEPTH];
  logic [PW-1:0]               pay_q [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] dep_vd, dep_vs, older;
  logic [ID_W:0]               occ_q;

  logic [DEPTH-1:0] valid, issued, vd_hit, vs_hit, vd_resp, vs_resp;
  logic [DEPTH-1:0] vd_done_eff, vs_done_eff, retire, ready, grant;
  logic [DEPTH-1:0] new_dep_vd, new_dep_vs;
  logic             any_ready, dispatch, alloc;
  logic [ID_W-1:0]  alloc_idx, sel_idx;
  logic [ID_W:0]    retire_cnt;
  dp_entry_t        new_ent;

  // Responses only count for entries that are live and already issued.
  always_comb begin
    vd_hit = '0;
    vs_hit = '0;
    for (int f = 0; f < NFU; f++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (vd_done_valid[f] && vd_done_id[f*ID_W +: ID_W] == ID_W'(k)) vd_hit[k] = 1'b1;
        if (vs_done_valid[f] && vs_done_id[f*ID_W +: ID_W] == ID_W'(k)) vs_hit[k] = 1'b1;
      end
    end
    retire_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]       = ent[i].valid;
      issued[i]      = ent[i].issued;
      vd_resp[i]     = vd_hit[i] & ent[i].valid & ent[i].issued;
      vs_resp[i]     = vs_hit[i] & ent[i].valid & ent[i].issued;
      vd_done_eff[i] = ent[i].vd_done | vd_resp[i];
      vs_done_eff[i] = ent[i].vs_done | vs_resp[i];
      retire[i]      = ent[i].valid & ent[i].issued & ent[i].vd_done & ent[i].vs_done;
      retire_cnt     = retire_cnt + (ID_W+1)'(retire[i]);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = ID_W'(i);
    end
    for (int j = 0; j < DEPTH; j++) begin
      new_dep_vd[j] = valid[j] & ent[j].has_vd & ~vd_done_eff[j] &
                      (in_vs_mask[vd_q[j]] | (in_has_vd & (in_vd == vd_q[j])));
      new_dep_vs[j] = valid[j] & in_has_vd & vs_q[j][in_vd] & ~vs_done_eff[j];
    end
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.has_vd = in_has_vd;
  end

  assign in_ready = ~(&valid);
  assign alloc    = in_valid & in_ready & ~flush;

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid[i] & ~issued[i] & (dep_vd[i] == '0) & (dep_vs[i] == '0) &
                 (int'(fu_q[i]) < NFU) & fu_ready[fu_q[i]];
    end
  end

  dp_age_select #(.DEPTH(DEPTH)) u_age_select (
    .older (older),
    .ready (ready),
    .grant (grant),
    .any   (any_ready)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_idx = ID_W'(i);
    end
  end

  assign dispatch   = any_ready & ~flush;
  assign dp_valid   = dispatch ? (NFU'(1) << fu_q[sel_idx]) : '0;
  assign dp_id      = dispatch ? sel_idx : '0;
  assign dp_payload = dispatch ? pay_q[sel_idx] : '0;
  assign occupancy  = occ_q;

  // Later assignments win: retire overrides a duplicate response, and the new
  // row written at allocation overrides any column clear landing on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent    <= '0;
      dep_vd <= '0;
      dep_vs <= '0;
      older  <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fu_q[i]  <= '0;
        vd_q[i]  <= '0;
        vs_q[i]  <= '0;
        pay_q[i] <= '0;
      end
    end else if (flush) begin
      ent    <= '0;
      dep_vd <= '0;
      dep_vs <= '0;
      older  <= '0;
      occ_q  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (vd_resp[k]) begin
          ent[k].vd_done <= 1'b1;
          for (int r = 0; r < DEPTH; r++) dep_vd[r][k] <= 1'b0;
        end
        if (vs_resp[k]) begin
          ent[k].vs_done <= 1'b1;
          for (int r = 0; r < DEPTH; r++) dep_vs[r][k] <= 1'b0;
        end
        if (retire[k]) begin
          ent[k] <= '0;
          for (int r = 0; r < DEPTH; r++) older[r][k] <= 1'b0;
        end
      end
      if (dispatch) begin
        ent[sel_idx].issued <= 1'b1;
        if (!ent[sel_idx].has_vd) ent[sel_idx].vd_done <= 1'b1;
        if (vs_q[sel_idx] == '0)  ent[sel_idx].vs_done <= 1'b1;
      end
      if (alloc) begin
        ent[alloc_idx]    <= new_ent;
        fu_q[alloc_idx]   <= in_fu;
        vd_q[alloc_idx]   <= in_vd;
        vs_q[alloc_idx]   <= in_vs_mask;
        pay_q[alloc_idx]  <= in_payload;
        dep_vd[alloc_idx] <= new_dep_vd;
        dep_vs[alloc_idx] <= new_dep_vs;
        older[alloc_idx]  <= valid & ~retire;
      end
      occ_q <= occ_q + (ID_W+1)'(alloc) - retire_cnt;
    end
  end

  a_resp_live: assert property (@(posedge clk) disable iff (!rst_n || flush)
    ((vd_hit | vs_hit) & ~(valid & issued)) == '0);

endmodule
